// File: rtl/mmio_io_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_io_responder_if
// Description : CPU memory-bus signals between the initiator and the MMIO
//               responder. The master drives command, address and write data.
//               The slave returns registered read data and the io_hit decode.
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_io_responder_if #(
    parameter int data_width = 16
) ();
    logic [1:0]            mem_cmd;
    logic [8:0]            mem_addr;
    logic [data_width-1:0] write_data;
    logic [data_width-1:0] read_data;
    logic                  io_hit;

    modport master (
        output mem_cmd,
        output mem_addr,
        output write_data,
        input  read_data,
        input  io_hit
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        input  write_data,
        output read_data,
        output io_hit
    );
endinterface
`default_nettype wire

// File: rtl/mmio_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : mmio_io_responder
// Description : Memory-mapped I/O responder. Synchronizes and debounces the
//               slide switches and push buttons, latches key-press events
//               (cleared on read), holds the LED register, and runs a
//               free-running 16-bit tick counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_io_responder #(
    parameter int         data_width      = 16,
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter logic [8:0] LED_ADDR        = 9'h100,
    parameter logic [8:0] SW_ADDR         = 9'h140,
    parameter logic [8:0] KEY_ADDR        = 9'h141,
    parameter logic [8:0] CNT_ADDR        = 9'h142
) (
    input  wire logic              clk,
    input  wire logic              reset,
    mmio_io_responder_if.slave     bus,
    input  wire logic [7:0]        SW,
    input  wire logic [3:0]        KEY_n,
    output logic      [7:0]        LEDR
);

    localparam int                 c_cnt_w     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_db_last   = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    // Bits [11:8] are the active-low keys (idle high), bits [7:0] the switches.
    localparam logic [11:0]        c_in_rst    = 12'hF00;
    localparam logic [1:0]         c_cmd_read  = 2'b01;
    localparam logic [1:0]         c_cmd_write = 2'b10;

    // Keys and switches share one input path so each bit gets identical treatment.
    logic [11:0]            w_raw;
    logic [11:0]            sync1_q;
    logic [11:0]            sync2_q;
    logic [11:0]            db_q;
    logic [11:0]            db_d;
    logic [c_cnt_w-1:0]     db_cnt_q [12];
    logic [c_cnt_w-1:0]     db_cnt_d [12];
    logic [7:0]             led_q;
    logic [7:0]             led_d;
    logic [3:0]             key_evt_q;
    logic [3:0]             key_evt_d;
    logic [15:0]            tick_q;
    logic [15:0]            tick_d;
    logic [data_width-1:0]  read_data_q;
    logic [data_width-1:0]  read_data_d;
    logic                   w_is_read;
    logic                   w_is_write;
    logic                   w_mapped;

    assign w_raw         = {KEY_n, SW};
    assign w_is_read     = (bus.mem_cmd == c_cmd_read);
    assign w_is_write    = (bus.mem_cmd == c_cmd_write);
    assign w_mapped      = (bus.mem_addr == LED_ADDR) || (bus.mem_addr == SW_ADDR) ||
                           (bus.mem_addr == KEY_ADDR) || (bus.mem_addr == CNT_ADDR);
    assign bus.io_hit    = (w_is_read || w_is_write) && w_mapped;
    assign bus.read_data = read_data_q;
    assign LEDR          = led_q;

    // Per-bit debounce: a bit follows its synchronized input only after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 12; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == c_db_last) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + c_cnt_one;
                end
            end
        end
    end

    // Bus side: LED write, read mux, clear-on-read key events, tick counter.
    always_comb begin
        led_d       = led_q;
        read_data_d = read_data_q;
        tick_d      = tick_q + 16'd1;
        key_evt_d   = key_evt_q;

        if (w_is_write && (bus.mem_addr == LED_ADDR)) begin
            led_d = bus.write_data[7:0];
        end

        if (w_is_read) begin
            read_data_d = '0;
            case (bus.mem_addr)
                LED_ADDR: read_data_d[7:0]  = led_q;
                SW_ADDR:  read_data_d[7:0]  = db_q[7:0];
                KEY_ADDR: read_data_d[3:0]  = key_evt_q;
                CNT_ADDR: read_data_d[15:0] = tick_q;
                default:  read_data_d       = '0;
            endcase
            if (bus.mem_addr == KEY_ADDR) begin
                key_evt_d = 4'b0000;
            end
        end

        // A press landing on the clearing edge survives into the next read.
        key_evt_d = key_evt_d | (db_q[11:8] & ~db_d[11:8]);
    end

    // All state registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= c_in_rst;
            sync2_q     <= c_in_rst;
            db_q        <= c_in_rst;
            for (int i = 0; i < 12; i++) begin
                db_cnt_q[i] <= '0;
            end
            led_q       <= '0;
            key_evt_q   <= '0;
            tick_q      <= '0;
            read_data_q <= '0;
        end else begin
            sync1_q     <= w_raw;
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            for (int i = 0; i < 12; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            led_q       <= led_d;
            key_evt_q   <= key_evt_d;
            tick_q      <= tick_d;
            read_data_q <= read_data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_io_responder
// Description : Self-checking bench for mmio_io_responder with
//               DEBOUNCE_CYCLES=4: table-driven bus vectors plus directed
//               sequences for debounce, key events, reset and counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_io_responder;

    localparam logic [1:0] c_none  = 2'b00;
    localparam logic [1:0] c_read  = 2'b01;
    localparam logic [1:0] c_write = 2'b10;
    localparam logic [1:0] c_rsvd  = 2'b11;
    localparam logic [8:0] c_led   = 9'h100;
    localparam logic [8:0] c_sw    = 9'h140;
    localparam logic [8:0] c_key   = 9'h141;
    localparam logic [8:0] c_cnt   = 9'h142;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] SW;
    logic [3:0] KEY_n;
    logic [7:0] LEDR;
    int         checks = 0;
    int         errors = 0;
    int         n;

    mmio_io_responder_if #(.data_width(16)) bus ();

    mmio_io_responder #(
        .data_width      (16),
        .DEBOUNCE_CYCLES (4),
        .LED_ADDR        (c_led),
        .SW_ADDR         (c_sw),
        .KEY_ADDR        (c_key),
        .CNT_ADDR        (c_cnt)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .SW    (SW),
        .KEY_n (KEY_n),
        .LEDR  (LEDR)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic        exp_hit;
        logic [15:0] exp_rd;
        logic [7:0]  exp_led;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
        bus.mem_cmd    = cmd;
        bus.mem_addr   = addr;
        bus.write_data = wd;
    endtask

    initial begin
        vecs[0]  = '{c_write, c_led,    16'h12C3, 1'b1, 16'h0000, 8'hC3};
        vecs[1]  = '{c_read,  c_led,    16'h0000, 1'b1, 16'h00C3, 8'hC3};
        vecs[2]  = '{c_write, c_sw,     16'hFFFF, 1'b1, 16'h00C3, 8'hC3};
        vecs[3]  = '{c_write, c_cnt,    16'hFFFF, 1'b1, 16'h00C3, 8'hC3};
        vecs[4]  = '{c_write, 9'h000,   16'hFFFF, 1'b0, 16'h00C3, 8'hC3};
        vecs[5]  = '{c_rsvd,  c_led,    16'h00FF, 1'b0, 16'h00C3, 8'hC3};
        vecs[6]  = '{c_none,  c_led,    16'h00EE, 1'b0, 16'h00C3, 8'hC3};
        vecs[7]  = '{c_read,  9'h000,   16'h0000, 1'b0, 16'h0000, 8'hC3};
        vecs[8]  = '{c_read,  c_sw,     16'h0000, 1'b1, 16'h0000, 8'hC3};
        vecs[9]  = '{c_read,  c_key,    16'h0000, 1'b1, 16'h0000, 8'hC3};
        vecs[10] = '{c_write, c_led,    16'hFFA5, 1'b1, 16'h0000, 8'hA5};
        vecs[11] = '{c_read,  c_led,    16'h0000, 1'b1, 16'h00A5, 8'hA5};
        vecs[12] = '{c_read,  9'h13F,   16'h0000, 1'b0, 16'h0000, 8'hA5};
        vecs[13] = '{c_read,  9'h143,   16'h0000, 1'b0, 16'h0000, 8'hA5};
        vecs[14] = '{c_read,  c_led,    16'h0000, 1'b1, 16'h00A5, 8'hA5};

        reset = 1'b1;
        SW    = 8'h00;
        KEY_n = 4'hF;
        drive(c_none, 9'h000, 16'h0000);
        step();
        step();
        check("reset_ledr", LEDR, 8'h00);
        check("reset_read_data", bus.read_data, 16'h0000);
        check("reset_io_hit", bus.io_hit, 1'b0);
        reset = 1'b0;
        step();

        // Table-driven bus vectors.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].cmd, vecs[i].addr, vecs[i].wdata);
            #1;
            check($sformatf("vec%0d_io_hit", i), bus.io_hit, vecs[i].exp_hit);
            step();
            check($sformatf("vec%0d_read_data", i), bus.read_data, vecs[i].exp_rd);
            check($sformatf("vec%0d_ledr", i), LEDR, vecs[i].exp_led);
        end
        drive(c_none, 9'h000, 16'h0000);
        step();

        // Clean switch edge: debounced value appears after 2+4 edges, and the
        // read issued after that edge shows it one edge later.
        SW = 8'h5A;
        drive(c_read, c_sw, 16'h0000);
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("sw_edge_e%0d", k), bus.read_data, (k >= 7) ? 16'h005A : 16'h0000);
        end

        // A 3-cycle pulse on SW[0] must never pass the debouncer.
        SW = 8'h5B;
        step();
        step();
        step();
        SW = 8'h5A;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("sw_glitch_%0d", k), bus.read_data, 16'h005A);
        end
        drive(c_none, 9'h000, 16'h0000);
        step();

        // KEY_n[2] press/release, then two reads of the key-event register.
        KEY_n = 4'b1011;
        repeat (10) step();
        KEY_n = 4'hF;
        repeat (10) step();
        drive(c_read, c_key, 16'h0000);
        step();
        check("key2_first_read", bus.read_data, 16'h0004);
        step();
        check("key2_second_read", bus.read_data, 16'h0000);
        drive(c_none, 9'h000, 16'h0000);
        step();

        // Press of KEY_n[1] whose debounced fall lands on the clearing edge.
        KEY_n = 4'b1101;
        repeat (5) step();
        drive(c_read, c_key, 16'h0000);
        step();
        check("key_clear_edge_read", bus.read_data, 16'h0000);
        step();
        check("key_clear_edge_next", bus.read_data, 16'h0002);
        drive(c_none, 9'h000, 16'h0000);
        KEY_n = 4'hF;
        repeat (10) step();

        // Latch events on keys 0 and 1, then reset asynchronously mid-cycle.
        KEY_n = 4'b1100;
        repeat (10) step();
        KEY_n = 4'hF;
        repeat (10) step();
        drive(c_read, c_led, 16'h0000);
        step();
        check("pre_reset_led_read", bus.read_data, 16'h00A5);
        drive(c_none, 9'h000, 16'h0000);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_ledr", LEDR, 8'h00);
        check("async_reset_read_data", bus.read_data, 16'h0000);
        step();
        step();
        drive(c_read, c_sw, 16'h0000);
        reset = 1'b0;
        step();
        check("post_reset_sw", bus.read_data, 16'h0000);
        drive(c_read, c_cnt, 16'h0000);
        step();
        check("cnt_first", bus.read_data, 16'h0001);
        step();
        check("cnt_consecutive", bus.read_data, 16'h0002);
        n = 3;
        drive(c_none, 9'h000, 16'h0000);
        step();
        n++;
        check("read_data_hold", bus.read_data, 16'h0002);
        while (n < 65535) begin
            step();
            n++;
        end
        drive(c_read, c_cnt, 16'h0000);
        step();
        check("cnt_ffff", bus.read_data, 16'hFFFF);
        step();
        check("cnt_wrap", bus.read_data, 16'h0000);
        drive(c_read, c_key, 16'h0000);
        step();
        check("post_reset_key_evt", bus.read_data, 16'h0000);
        check("post_reset_ledr", LEDR, 8'h00);
        drive(c_none, 9'h000, 16'h0000);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
